axilite_csr_slave: RTL and testbench

- AXI4-Lite responder (slave end of the team's AXI-Lite interface) that exposes the control/status register file of the AXIS-I2C bridge.
- Sits between the system interconnect (master) and the bridge core.
- Drives control fields to the core and returns status and sticky interrupt flags from the core.
- Single 32-bit data path; independent read and write channels.

---
 rtl/axilite_pkg.sv | 23 ++
 rtl/axilite_slave_if.sv | 187 ++++++++++++++++++
 rtl/axilite_csr_slave.sv | 147 ++++++++++++++
 tb/tb_axilite_csr_slave.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// Shared constants and state types for the AXI4-Lite CSR responder.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index of each register, i.e. byte offset bits [4:2].
  localparam logic [2:0] CTRL_OFS     = 3'd0;
  localparam logic [2:0] PRESCALE_OFS = 3'd1;
  localparam logic [2:0] STATUS_OFS   = 3'd2;
  localparam logic [2:0] IRQ_PEND_OFS = 3'd3;
  localparam logic [2:0] IRQ_MASK_OFS = 3'd4;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int unsigned i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/axilite_slave_if.sv
// AXI4-Lite channel handling: write/read FSMs and AW/W capture, exposing a
// simple single-cycle register access port to the register file.
module axilite_slave_if
  import axilite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic [3:0]            wr_strb_o,
  input  logic                  wr_err_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i,
  input  logic                  rd_err_i
);

  wr_state_e             wstate_q, wstate_d;
  rd_state_e             rstate_q, rstate_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  aw_hs, w_hs, ar_hs, have_aw, have_w;

  assign aw_hs   = s_axil_awvalid && awready_q;
  assign w_hs    = s_axil_wvalid && wready_q;
  assign ar_hs   = s_axil_arvalid && arready_q;
  assign have_aw = aw_held_q || aw_hs;
  assign have_w  = w_held_q || w_hs;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en_o   = 1'b0;
    wr_addr_o = aw_held_q ? awaddr_q : s_axil_awaddr;
    wr_data_o = w_held_q ? wdata_q : s_axil_wdata;
    wr_strb_o = w_held_q ? wstrb_q : s_axil_wstrb;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata;
          wstrb_d  = s_axil_wstrb;
        end
        // Commit on whichever edge completes the second handshake.
        if (have_aw && have_w) begin
          wr_en_o   = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err_i ? RESP_SLVERR : RESP_OKAY;
          wstate_d  = W_RESP;
        end else begin
          awready_d = !have_aw;
          wready_d  = !have_w;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_en_o   = 1'b0;
    rd_addr_o = s_axil_araddr;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rd_en_o   = 1'b1;
          rdata_d   = rd_data_i;
          rresp_d   = rd_err_i ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: rtl/axilite_csr_slave.sv
// Control/status register file of the AXIS-I2C bridge behind an AXI4-Lite
// responder: CTRL, PRESCALE, STATUS, sticky IRQ_PEND (W1C) and IRQ_MASK.
module axilite_csr_slave
  import axilite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned IRQ_WIDTH      = 4,
  parameter logic [31:0] CTRL_RESET     = 32'h0,
  parameter logic [15:0] PRESCALE_RESET = 16'd250
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [31:0]           ctrl_o,
  output logic [15:0]           prescale_o,
  input  logic [31:0]           status_i,
  input  logic [IRQ_WIDTH-1:0]  irq_set_i,
  output logic                  irq_o
);

  logic                  wr_en, rd_en, wr_err, rd_err, wr_hit, rd_hit;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]           wr_data, rd_data, bmask;
  logic [3:0]            wr_strb;
  logic [2:0]            wr_idx, rd_idx;

  logic [31:0]           ctrl_q, ctrl_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [IRQ_WIDTH-1:0]  pend_q, pend_d, pend_clr, mask_q, mask_d;
  logic                  irq_q, irq_d;

  axilite_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_if (
    .aclk           (aclk),
    .areset         (areset),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .wr_strb_o      (wr_strb),
    .wr_err_i       (wr_err),
    .rd_en_o        (rd_en),
    .rd_addr_o      (rd_addr),
    .rd_data_i      (rd_data),
    .rd_err_i       (rd_err)
  );

  // Only bits [4:2] select a register; anything set above bit 4 misses.
  assign wr_idx = wr_addr[4:2];
  assign rd_idx = rd_addr[4:2];
  assign wr_hit = ((wr_addr >> 5) == '0) && (wr_idx <= IRQ_MASK_OFS);
  assign rd_hit = ((rd_addr >> 5) == '0) && (rd_idx <= IRQ_MASK_OFS);
  assign wr_err = !wr_hit;
  assign rd_err = !rd_hit;

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (rd_idx)
        CTRL_OFS:     rd_data = ctrl_q;
        PRESCALE_OFS: rd_data[15:0] = prescale_q;
        STATUS_OFS:   rd_data = status_i;
        IRQ_PEND_OFS: rd_data[IRQ_WIDTH-1:0] = pend_q;
        IRQ_MASK_OFS: rd_data[IRQ_WIDTH-1:0] = mask_q;
        default:      rd_data = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    mask_d     = mask_q;
    pend_clr   = '0;
    bmask      = strb_mask(wr_strb);
    if (wr_en && wr_hit) begin
      case (wr_idx)
        CTRL_OFS:     ctrl_d = (ctrl_q & ~bmask) | (wr_data & bmask);
        PRESCALE_OFS: prescale_d = (prescale_q & ~bmask[15:0]) | (wr_data[15:0] & bmask[15:0]);
        IRQ_PEND_OFS: pend_clr = wr_data[IRQ_WIDTH-1:0] & bmask[IRQ_WIDTH-1:0];
        IRQ_MASK_OFS: mask_d = (mask_q & ~bmask[IRQ_WIDTH-1:0])
                             | (wr_data[IRQ_WIDTH-1:0] & bmask[IRQ_WIDTH-1:0]);
        default: ;
      endcase
    end
    // A set pulse on the same edge as its clear keeps the flag.
    pend_d = (pend_q & ~pend_clr) | irq_set_i;
    irq_d  = |(pend_q & mask_q);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ctrl_q     <= CTRL_RESET;
      prescale_q <= PRESCALE_RESET;
      pend_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign prescale_o = prescale_q;
  assign irq_o      = irq_q;

  logic unused_sig;
  assign unused_sig = ^{s_axil_awprot, s_axil_arprot, wr_addr[1:0], rd_addr[1:0], rd_en};

endmodule

// File: tb/tb_axilite_csr_slave.sv
// Self-checking bench for axilite_csr_slave: register model plus queues of
// expected B/R responses, popped as the DUT presents each response.
module tb_axilite_csr_slave;

  localparam int TMO = 50;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [7:0]  s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [31:0] ctrl_o;
  logic [15:0] prescale_o;
  logic [31:0] status_i = '0;
  logic [3:0]  irq_set_i = '0;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ctrl;
  logic [15:0] m_pre;
  logic [3:0]  m_pend, m_mask;
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];

  always #5 aclk = ~aclk;

  axilite_csr_slave #(
    .ADDR_WIDTH(8), .IRQ_WIDTH(4), .CTRL_RESET(32'h0), .PRESCALE_RESET(16'd250)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .ctrl_o(ctrl_o), .prescale_o(prescale_o), .status_i(status_i),
    .irq_set_i(irq_set_i), .irq_o(irq_o)
  );

  function automatic void model_reset();
    m_ctrl = 32'h0; m_pre = 16'd250; m_pend = '0; m_mask = '0;
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    if (a[7:5] != 3'd0 || a[4:2] > 3'd4) return 2'b10;
    case (a[4:2])
      3'd0: for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[b*8 +: 8] = d[b*8 +: 8];
      3'd1: for (int b = 0; b < 2; b++) if (s[b]) m_pre[b*8 +: 8] = d[b*8 +: 8];
      3'd3: for (int i = 0; i < 4; i++) if (s[0] && d[i]) m_pend[i] = 1'b0;
      3'd4: if (s[0]) m_mask = d[3:0];
      default: ;
    endcase
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [7:0] a);
    if (a[7:5] != 3'd0 || a[4:2] > 3'd4) return {2'b10, 32'h0};
    case (a[4:2])
      3'd0:    return {2'b00, m_ctrl};
      3'd1:    return {2'b00, 16'h0, m_pre};
      3'd2:    return {2'b00, status_i};
      3'd3:    return {2'b00, 28'h0, m_pend};
      default: return {2'b00, 28'h0, m_mask};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the B handshake.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] exp;
    b_exp_q.push_back(model_write(addr, data, strb));
    fork
      begin
        int n = 0;
        repeat (aw_dly) @(negedge aclk);
        s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
        while (!s_axil_awready && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) begin
          checks++; errors++; $display("FAIL aw_timeout got awready=0 want 1");
        end else begin @(posedge aclk); @(negedge aclk); end
        s_axil_awvalid = 1'b0;
      end
      begin
        int n = 0;
        repeat (w_dly) @(negedge aclk);
        s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
        while (!s_axil_wready && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) begin
          checks++; errors++; $display("FAIL w_timeout got wready=0 want 1");
        end else begin @(posedge aclk); @(negedge aclk); end
        s_axil_wvalid = 1'b0;
      end
    join
    checks++;
    if (s_axil_bvalid !== 1'b1) begin
      errors++; $display("FAIL b_latency got bvalid=%b want 1", s_axil_bvalid);
    end
    repeat (b_dly) begin
      checks++;
      if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0 || s_axil_bvalid !== 1'b1) begin
        errors++;
        $display("FAIL b_stall got awready=%b wready=%b bvalid=%b want 0 0 1",
                 s_axil_awready, s_axil_wready, s_axil_bvalid);
      end
      @(negedge aclk);
    end
    exp = b_exp_q.pop_front();
    checks++;
    if (s_axil_bresp !== exp) begin
      errors++; $display("FAIL bresp addr=%h got %b want %b", addr, s_axil_bresp, exp);
    end
    s_axil_bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    s_axil_bready = 1'b0;
    checks++;
    if (s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
      errors++;
      $display("FAIL b_release got bvalid=%b awready=%b wready=%b want 0 1 1",
               s_axil_bvalid, s_axil_awready, s_axil_wready);
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
    logic [33:0] exp;
    int n = 0;
    repeat (ar_dly) @(negedge aclk);
    r_exp_q.push_back(model_read(addr));
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    while (!s_axil_arready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) begin
      checks++; errors++; $display("FAIL ar_timeout got arready=0 want 1");
    end else begin @(posedge aclk); @(negedge aclk); end
    s_axil_arvalid = 1'b0;
    checks++;
    if (s_axil_rvalid !== 1'b1 || s_axil_arready !== 1'b0) begin
      errors++;
      $display("FAIL r_latency got rvalid=%b arready=%b want 1 0", s_axil_rvalid, s_axil_arready);
    end
    exp = r_exp_q.pop_front();
    repeat (r_dly + 1) begin
      checks++;
      if ({s_axil_rresp, s_axil_rdata} !== exp || s_axil_rvalid !== 1'b1) begin
        errors++;
        $display("FAIL rdata addr=%h got resp=%b data=%h valid=%b want resp=%b data=%h",
                 addr, s_axil_rresp, s_axil_rdata, s_axil_rvalid, exp[33:32], exp[31:0]);
      end
      @(negedge aclk);
    end
    s_axil_rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    s_axil_rready = 1'b0;
    checks++;
    if (s_axil_rvalid !== 1'b0 || s_axil_arready !== 1'b1) begin
      errors++;
      $display("FAIL r_release got rvalid=%b arready=%b want 0 1", s_axil_rvalid, s_axil_arready);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; model_reset();
    repeat (3) @(negedge aclk);
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b0 ||
        {s_axil_bresp, s_axil_rresp} !== 4'b0 || s_axil_rdata !== 32'h0 ||
        ctrl_o !== 32'h0 || prescale_o !== 16'd250 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b%b%b bv=%b rv=%b rdata=%h ctrl=%h pre=%h irq=%b want zeros ctrl=0 pre=00fa",
               s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
               s_axil_rdata, ctrl_o, prescale_o, irq_o);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset got %b%b%b want 111",
               s_axil_awready, s_axil_wready, s_axil_arready);
    end
    status_i = 32'hC0DE_0042;
    foreach (r_exp_q[i]) r_exp_q.delete(i);
    for (int a = 0; a < 8; a++) axi_read(8'(a * 4), 0, 0);
    axi_read(8'h84, 0, 0);
  endtask

  task automatic test_same_cycle();
    axi_write(8'h04, 32'hDEAD1234, 4'b0011, 0, 0, 0);
    checks++;
    if (prescale_o !== 16'h1234) begin
      errors++; $display("FAIL prescale_o got %h want 1234", prescale_o);
    end
    axi_read(8'h04, 0, 0);
  endtask

  task automatic test_w_first();
    axi_write(8'h00, 32'hA5A5A5A5, 4'hF, 2, 0, 3);
    checks++;
    if (ctrl_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL ctrl_o got %h want a5a5a5a5", ctrl_o);
    end
    axi_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, 2, 1);
    axi_write(8'h1C, 32'h12345678, 4'hF, 1, 1, 0);
    axi_read(8'h00, 1, 2);
  endtask

  task automatic test_irq();
    irq_set_i = 4'b0101;
    @(negedge aclk);
    irq_set_i = 4'b0000;
    m_pend |= 4'b0101;
    axi_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
    checks++;
    if (irq_o !== 1'b1) begin
      errors++; $display("FAIL irq_on got %b want 1", irq_o);
    end
    fork
      axi_write(8'h0C, 32'h1, 4'hF, 0, 0, 0);
      begin irq_set_i = 4'b0001; @(negedge aclk); irq_set_i = 4'b0000; end
    join
    m_pend |= 4'b0001;
    axi_read(8'h0C, 0, 0);
    axi_write(8'h0C, 32'hF, 4'h0, 0, 0, 0);
    axi_read(8'h0C, 0, 0);
    axi_write(8'h0C, 32'h5, 4'hF, 0, 0, 0);
    axi_read(8'h0C, 0, 0);
    checks++;
    if (irq_o !== 1'b0) begin
      errors++; $display("FAIL irq_off got %b want 0", irq_o);
    end
  endtask

  task automatic test_reset_mid();
    s_axil_awaddr = 8'h00; s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    s_axil_araddr = 8'h00; s_axil_arvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    checks++;
    if (s_axil_bvalid !== 1'b1 || s_axil_rvalid !== 1'b1) begin
      errors++; $display("FAIL mid_pending got bvalid=%b rvalid=%b want 1 1", s_axil_bvalid, s_axil_rvalid);
    end
    areset = 1'b1; @(negedge aclk); areset = 1'b0; model_reset();
    checks++;
    if (s_axil_bvalid !== 1'b0 || s_axil_rvalid !== 1'b0 || ctrl_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got bvalid=%b rvalid=%b ctrl=%h want 0 0 0", s_axil_bvalid, s_axil_rvalid, ctrl_o);
    end
    @(negedge aclk);
    s_axil_awaddr = 8'h04; s_axil_awvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0;
    checks++;
    if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b1) begin
      errors++; $display("FAIL aw_capture got awready=%b wready=%b want 0 1", s_axil_awready, s_axil_wready);
    end
    areset = 1'b1; @(negedge aclk); areset = 1'b0; @(negedge aclk);
    s_axil_wdata = 32'h0000BEEF; s_axil_wvalid = 1'b1;
    @(negedge aclk);
    s_axil_wvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_axil_bvalid !== 1'b0 || prescale_o !== 16'd250) begin
      errors++; $display("FAIL aw_discard got bvalid=%b prescale=%h want 0 00fa", s_axil_bvalid, prescale_o);
    end
    areset = 1'b1; @(negedge aclk); areset = 1'b0; @(negedge aclk);
    axi_read(8'h04, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int t = 0; t < 1000; t++) begin
      int idx = $urandom_range(0, 8);
      a = (idx == 8) ? 8'(8'h80 | ($urandom_range(0, 7) * 4)) : 8'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        status_i = $urandom;
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) begin
        logic [3:0] s = 4'($urandom_range(0, 15));
        irq_set_i = s; @(negedge aclk); irq_set_i = '0; m_pend |= s;
      end
    end
    @(negedge aclk);
    checks++;
    if (irq_o !== |(m_pend & m_mask)) begin
      errors++; $display("FAIL irq_final got %b want %b", irq_o, |(m_pend & m_mask));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_same_cycle();
    test_w_first();
    test_irq();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
